filter2d_stream: RTL and testbench
==================================

FILTER2D_STREAM -- requirements
Module: filter2d_stream

Interface
REQ-001 Parameters SHALL be as follows.
- IMG_W, 256: image width in pixels.
- IMG_H, 256: image height in pixels.
- PIX_W, 8: pixel width.
- COEF_W, 8: signed coefficient width.
- SHIFT, 7: output normalisation right-shift; SHIFT SHALL be >= 1.
REQ-002 Ports SHALL be as follows.
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  frame start pulse.
- border_mode  in  1  0 = zero padding, 1 = edge replicate; sampled at accepted start.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the last pixel is accepted.
- mem_rd  out  1  memory read request.
- rd_addr  out  ADDR_W  = clog2(IMG_W*IMG_H); row-major address y*IMG_W+x.
- rd_data  in  PIX_W  valid exactly one cycle after mem_rd.
- o_valid  out  1  output pixel valid.
- o_ready  in  1  downstream accept.
- o_data  out  PIX_W  filtered pixel.
- h_write  in  1  coefficient write strobe.
- h_idx  in  4  tap index 0..8, row-major from top-left.
- h_data  in  COEF_W  signed coefficient.

Function
REQ-003 The state machine SHALL use states IDLE, FETCH, ROUND, OUT; transitions:
- IDLE->FETCH on start.
- FETCH->ROUND after tap 8.
- ROUND->OUT.
- OUT->FETCH on o_valid&&o_ready, or OUT->IDLE if the accepted pixel was the last.
REQ-004 start while busy SHALL be ignored; a frame SHALL begin at pixel (0,0) and scan x fastest.
REQ-005 In FETCH, tap k (k=0..8) SHALL be issued in cycle k, at address (y+dy)*IMG_W+(x+dx), with dy=k/3-1 and dx=k%3-1.
REQ-006 Out-of-bounds taps SHALL be handled per border_mode.
- border_mode=0: mem_rd SHALL be 0 and the tap SHALL contribute 0.
- border_mode=1: coordinates SHALL be clamped to [0,IMG_W-1] and [0,IMG_H-1], and mem_rd SHALL be 1.
REQ-007 In the cycle after tap k, acc SHALL be updated as acc = (k==0 ? 0 : acc) + unsigned(rd_data)*h[k]; ACC_W = PIX_W+COEF_W+5, signed.
REQ-008 ROUND SHALL compute r = (acc + 2^(SHIFT-1)) >>> SHIFT and clamp it to [0, 2^PIX_W-1]; the result SHALL be registered into o_data.
REQ-009 o_valid SHALL assert in OUT and hold until o_ready; o_data SHALL be stable while o_valid=1 and o_ready=0, with no mem_rd issued.
REQ-010 With o_ready held at 1, the pixel period SHALL be 11 cycles, and the latency from start to the first o_valid SHALL be 11 cycles.
REQ-011 done SHALL pulse in the cycle after the last pixel (IMG_W-1, IMG_H-1) is accepted; busy SHALL fall in the same cycle.
REQ-012 h_write SHALL be accepted only in IDLE; it SHALL be ignored while busy or when h_idx>8.
REQ-013 mem_rd SHALL be 0 outside FETCH.

Reset
REQ-014 On reset, the following SHALL hold.
- State = IDLE.
- busy, done, mem_rd, o_valid = 0.
- o_data, acc, x, y = 0.
- rd_addr = 0.
- h = {8,16,8,16,32,16,8,16,8}.
REQ-015 Reset asserted mid-frame SHALL abort the frame within one cycle, with no done pulse.

Configuration
REQ-016 When macro FILTER2D_ABS_EN is defined, ROUND SHALL use |r| before clamping (edge-magnitude mode); when it is undefined, negative r SHALL clamp to 0.

Structure
REQ-017 Package filter2d_pkg SHALL hold:
- the state enum;
- the tap dx/dy constant tables;
- the default coefficient array;
- the ACC_W width function.
REQ-018 Sub-module filter2d_addr_gen SHALL compute the clamped address and the in-bounds flag from x, y, tap index, and border_mode.

Verification
REQ-019 The bench SHALL cover these directed scenarios, using IMG_W=IMG_H=4 unless stated otherwise.
- Identity kernel (h4=128, others 0), pixel = 16*y+x -> output equals input for all 16 pixels.
- Default kernel, constant 100 image, border_mode=1 -> all outputs 100.
- Default kernel, constant 100 image, border_mode=0 -> corner 56 ((7200+64)>>7), edge 75, interior 100; 4 mem_rd per corner.
- o_ready=0 for 20 cycles at pixel 5 -> o_valid and o_data held, mem_rd=0 throughout; frame completes with 16 outputs and 1 done.
- Kernel all -16, image 255 -> output 0 (macro undefined) or 255 (FILTER2D_ABS_EN defined); start and h_write while busy have no effect.
- Reset at pixel 7 -> outputs idle next cycle; a subsequent start produces a full 16-pixel frame with default coefficients.

Source files
------------

// File: rtl/filter2d_pkg.sv
// Shared state encoding, 3x3 tap geometry and default smoothing kernel for filter2d_stream.
package filter2d_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, ROUND, OUT} state_t;

  localparam int NTAPS = 9;

  // Row-major from the top-left tap: dx = k%3-1, dy = k/3-1.
  localparam int TAP_DX [NTAPS] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};
  localparam int TAP_DY [NTAPS] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};

  localparam int H_DEFAULT [NTAPS] = '{8, 16, 8, 16, 32, 16, 8, 16, 8};

  function automatic int acc_w(input int pix_w, input int coef_w);
    return pix_w + coef_w + 5;
  endfunction

endpackage

// File: rtl/filter2d_addr_gen.sv
// Maps (x, y, tap) to a row-major memory address with edge clamping, plus the in-bounds flag.
// Purely combinational; zero-padding mode drives address 0 for taps that fall off the image.
module filter2d_addr_gen
  import filter2d_pkg::*;
#(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int XW     = 8,
  parameter int YW     = 8,
  parameter int ADDR_W = 16
) (
  input  logic [XW-1:0]     x,
  input  logic [YW-1:0]     y,
  input  logic [3:0]        tap,
  input  logic              border_mode,
  output logic [ADDR_W-1:0] addr,
  output logic              in_bounds
);

  int tx, ty, cx, cy;

  always_comb begin
    tx = int'(x) + TAP_DX[tap];
    ty = int'(y) + TAP_DY[tap];
    in_bounds = (tx >= 0) && (tx < IMG_W) && (ty >= 0) && (ty < IMG_H);
    cx = (tx < 0) ? 0 : ((tx > IMG_W - 1) ? IMG_W - 1 : tx);
    cy = (ty < 0) ? 0 : ((ty > IMG_H - 1) ? IMG_H - 1 : ty);
    addr = (border_mode || in_bounds) ? ADDR_W'(cy * IMG_W + cx) : '0;
  end

endmodule

// File: rtl/filter2d_stream.sv
// Streaming 3x3 convolution over a memory-resident image: 9 tap reads, round/clamp, valid/ready output.
// Define FILTER2D_ABS_EN to output |r| (edge-magnitude mode) instead of clamping negatives to 0.
module filter2d_stream
  import filter2d_pkg::*;
#(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8,
  parameter int SHIFT  = 7,
  localparam int ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     border_mode,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_rd,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [PIX_W-1:0]         rd_data,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [PIX_W-1:0]         o_data,
  input  logic                     h_write,
  input  logic [3:0]               h_idx,
  input  logic signed [COEF_W-1:0] h_data
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int AW = acc_w(PIX_W, COEF_W);
  localparam logic signed [AW-1:0] RND_HALF = AW'(1 << (SHIFT - 1));
  localparam logic signed [AW-1:0] PIX_MAX  = AW'((1 << PIX_W) - 1);

  state_t                   state_q, state_d;
  logic [XW-1:0]            x_q, x_d;
  logic [YW-1:0]            y_q, y_d;
  logic [3:0]               tap_q, tap_d;
  logic [3:0]               ptap_q, ptap_d;
  logic                     pend_q, pend_d;
  logic                     puse_q, puse_d;
  logic                     bm_q, bm_d;
  logic                     done_q, done_d;
  logic signed [AW-1:0]     acc_q, acc_d;
  logic [PIX_W-1:0]         odata_q, odata_d;
  logic signed [COEF_W-1:0] h_q [NTAPS];
  logic signed [COEF_W-1:0] h_d [NTAPS];

  logic [ADDR_W-1:0]        gen_addr;
  logic                     gen_inb;
  logic                     last_pix;
  logic signed [AW-1:0]     pix_ext, coef_ext, prod, acc_sum, rnd;
  logic [PIX_W-1:0]         rnd_pix;

  filter2d_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .XW    (XW),
    .YW    (YW),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .x          (x_q),
    .y          (y_q),
    .tap        (tap_q),
    .border_mode(bm_q),
    .addr       (gen_addr),
    .in_bounds  (gen_inb)
  );

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign o_valid  = (state_q == OUT);
  assign o_data   = odata_q;
  assign mem_rd   = (state_q == FETCH) && (gen_inb || bm_q);
  assign rd_addr  = (state_q == FETCH) ? gen_addr : '0;
  assign last_pix = (x_q == XW'(IMG_W - 1)) && (y_q == YW'(IMG_H - 1));

  // rd_data belongs to the tap issued last cycle; skipped taps contribute nothing.
  always_comb begin
    pix_ext  = {{(AW - PIX_W){1'b0}}, rd_data};
    coef_ext = {{(AW - COEF_W){h_q[ptap_q][COEF_W-1]}}, h_q[ptap_q]};
    prod     = puse_q ? (pix_ext * coef_ext) : '0;
    acc_sum  = ((ptap_q == 4'd0) ? '0 : acc_q) + prod;
    rnd      = (acc_sum + RND_HALF) >>> SHIFT;
`ifdef FILTER2D_ABS_EN
    if (rnd < 0) rnd = -rnd;
`endif
    if (rnd < 0)            rnd_pix = '0;
    else if (rnd > PIX_MAX) rnd_pix = '1;
    else                    rnd_pix = rnd[PIX_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    tap_d   = tap_q;
    ptap_d  = ptap_q;
    pend_d  = 1'b0;
    puse_d  = puse_q;
    bm_d    = bm_q;
    done_d  = 1'b0;
    acc_d   = acc_q;
    odata_d = odata_q;
    for (int i = 0; i < NTAPS; i++) h_d[i] = h_q[i];

    if (pend_q) acc_d = acc_sum;

    case (state_q)
      IDLE: begin
        if (h_write && (h_idx <= 4'd8)) h_d[h_idx] = h_data;
        if (start) begin
          state_d = FETCH;
          bm_d    = border_mode;
          x_d     = '0;
          y_d     = '0;
          tap_d   = 4'd0;
        end
      end
      FETCH: begin
        pend_d = 1'b1;
        ptap_d = tap_q;
        puse_d = mem_rd;
        if (tap_q == 4'd8) begin
          state_d = ROUND;
          tap_d   = 4'd0;
        end else begin
          tap_d = tap_q + 4'd1;
        end
      end
      ROUND: begin
        odata_d = rnd_pix;
        state_d = OUT;
      end
      OUT: begin
        if (o_ready) begin
          if (last_pix) begin
            state_d = IDLE;
            done_d  = 1'b1;
            x_d     = '0;
            y_d     = '0;
          end else begin
            state_d = FETCH;
            if (x_q == XW'(IMG_W - 1)) begin
              x_d = '0;
              y_d = y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      tap_q   <= '0;
      ptap_q  <= '0;
      pend_q  <= 1'b0;
      puse_q  <= 1'b0;
      bm_q    <= 1'b0;
      done_q  <= 1'b0;
      acc_q   <= '0;
      odata_q <= '0;
      for (int i = 0; i < NTAPS; i++) h_q[i] <= COEF_W'(H_DEFAULT[i]);
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      tap_q   <= tap_d;
      ptap_q  <= ptap_d;
      pend_q  <= pend_d;
      puse_q  <= puse_d;
      bm_q    <= bm_d;
      done_q  <= done_d;
      acc_q   <= acc_d;
      odata_q <= odata_d;
      for (int i = 0; i < NTAPS; i++) h_q[i] <= h_d[i];
    end
  end

endmodule

// File: tb/tb_filter2d_stream.sv
// Directed bench for filter2d_stream on a 4x4 image; COEF_W=9 so the identity tap 128 is representable.
// Expected values follow FILTER2D_ABS_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_filter2d_stream;

  localparam int W = 4;
  localparam int H = 4;
  localparam int NPIX = W * H;

  logic              clk = 1'b0;
  logic              reset, start, border_mode;
  logic              busy, done, mem_rd;
  logic [3:0]        rd_addr;
  logic [7:0]        rd_data;
  logic              o_valid, o_ready;
  logic [7:0]        o_data;
  logic              h_write;
  logic [3:0]        h_idx;
  logic signed [8:0] h_data;

  always #5 clk = ~clk;

  filter2d_stream #(
    .IMG_W(W), .IMG_H(H), .PIX_W(8), .COEF_W(9), .SHIFT(7)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .border_mode(border_mode),
    .busy(busy), .done(done), .mem_rd(mem_rd), .rd_addr(rd_addr), .rd_data(rd_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .h_write(h_write), .h_idx(h_idx), .h_data(h_data)
  );

  // Image memory: data one cycle after the request; junk when no read was issued.
  logic [7:0] img [NPIX];
  always @(posedge clk) rd_data <= mem_rd ? img[rd_addr] : 8'hA5;

  int         n_assert, n_fail;
  logic [7:0] got [NPIX];
  int         rd_pix [NPIX];
  int         n_out, n_done, n_rd, first_c, second_c, n_stall;
  bit         finished;
  int         hk [9];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_h(input int idx, input int val);
    @(negedge clk);
    h_write = 1'b1;
    h_idx   = 4'(idx);
    h_data  = 9'(val);
    @(negedge clk);
    h_write = 1'b0;
  endtask

  function automatic int ref_pix(input int x, input int y, input bit bm);
    int s, r, xx, yy;
    s = 0;
    for (int k = 0; k < 9; k++) begin
      xx = x + (k % 3) - 1;
      yy = y + (k / 3) - 1;
      if (xx < 0 || xx >= W || yy < 0 || yy >= H) begin
        if (!bm) continue;
        xx = (xx < 0) ? 0 : ((xx >= W) ? W - 1 : xx);
        yy = (yy < 0) ? 0 : ((yy >= H) ? H - 1 : yy);
      end
      s += int'(img[yy * W + xx]) * hk[k];
    end
    r = (s + 64) >>> 7;
`ifdef FILTER2D_ABS_EN
    if (r < 0) r = -r;
`endif
    return (r < 0) ? 0 : ((r > 255) ? 255 : r);
  endfunction

  function automatic int exp_b(input int i);
    bit bx, by;
    bx = (i % W == 0) || (i % W == W - 1);
    by = (i / W == 0) || (i / W == H - 1);
    return (bx && by) ? 56 : ((bx || by) ? 75 : 100);
  endfunction

  // One frame: start pulse, then per-cycle observation at negedge until done or the budget runs out.
  task automatic run_frame(input logic bm, input int stall_pix, input int abort_pix, input int poke_c);
    int         rd_cur;
    logic [7:0] held;
    logic       prev_v;
    n_out = 0; n_done = 0; n_rd = 0; first_c = -1; second_c = -1; n_stall = 0;
    finished = 1'b0; rd_cur = 0; prev_v = 1'b0; held = '0;
    @(negedge clk);
    start = 1'b1;
    border_mode = bm;
    for (int c = 1; c <= 600 && !finished; c++) begin
      @(negedge clk);
      start   = (c == poke_c);
      h_write = (c == poke_c);
      h_idx   = 4'd4;
      h_data  = 9'sd127;
      o_ready = 1'b1;
      if (mem_rd) begin rd_cur++; n_rd++; end
      if (done) begin n_done++; finished = 1'b1; end
      if (o_valid && !prev_v) begin
        if (first_c < 0) first_c = c;
        else if (second_c < 0) second_c = c;
      end
      prev_v = o_valid;
      if (abort_pix >= 0 && o_valid && n_out == abort_pix) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_o_valid", o_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_mem_rd", mem_rd, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        chk("abort_done_later", done, 0);
        chk("abort_busy_later", busy, 0);
        return;
      end
      if (stall_pix >= 0 && o_valid && n_out == stall_pix && n_stall < 20) begin
        o_ready = 1'b0;
        if (n_stall == 0) held = o_data;
        else begin
          chk("stall_o_valid", o_valid, 1);
          chk("stall_o_data", o_data, held);
        end
        chk("stall_mem_rd", mem_rd, 0);
        n_stall++;
      end
      if (o_valid && o_ready && n_out < NPIX) begin
        got[n_out] = o_data;
        rd_pix[n_out] = rd_cur;
        rd_cur = 0;
        n_out++;
      end
    end
    chk("frame_done_seen", finished, 1);
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    reset = 1'b1; start = 1'b0; border_mode = 1'b0; o_ready = 1'b1;
    h_write = 1'b0; h_idx = '0; h_data = '0;
    for (int i = 0; i < NPIX; i++) img[i] = 8'd100;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_data", o_data, 0);
    chk("rst_rd_addr", rd_addr, 0);
    reset = 1'b0;
    @(negedge clk);

    // Default kernel, constant image, edge replicate.
    run_frame(1'b1, -1, -1, -1);
    chk("A_n_out", n_out, 16);
    chk("A_n_done", n_done, 1);
    chk("A_busy_at_done", busy, 0);
    chk("A_latency", first_c, 11);
    chk("A_period", second_c - first_c, 11);
    for (int i = 0; i < NPIX; i++) chk($sformatf("A_pix%0d", i), got[i], 100);

    // Default kernel, constant image, zero padding.
    run_frame(1'b0, -1, -1, -1);
    chk("B_n_out", n_out, 16);
    chk("B_n_done", n_done, 1);
    for (int i = 0; i < NPIX; i++) chk($sformatf("B_pix%0d", i), got[i], exp_b(i));
    chk("B_rd_corner0", rd_pix[0], 4);
    chk("B_rd_corner15", rd_pix[15], 4);
    chk("B_rd_edge1", rd_pix[1], 6);
    chk("B_rd_total", n_rd, 100);

    // Identity kernel on a ramp, 20-cycle stall at pixel 5.
    for (int k = 0; k < 9; k++) set_h(k, (k == 4) ? 128 : 0);
    for (int i = 0; i < NPIX; i++) img[i] = 8'(16 * (i / W) + (i % W));
    run_frame(1'b1, 5, -1, -1);
    chk("C_stall_len", n_stall, 20);
    chk("C_n_out", n_out, 16);
    chk("C_n_done", n_done, 1);
    for (int i = 0; i < NPIX; i++) chk($sformatf("C_pix%0d", i), got[i], 16 * (i / W) + (i % W));

    // All -16 kernel on a saturated image; start and h_write poked mid-frame.
    for (int k = 0; k < 9; k++) set_h(k, -16);
    for (int i = 0; i < NPIX; i++) img[i] = 8'd255;
    run_frame(1'b1, -1, -1, 30);
    chk("D_n_out", n_out, 16);
    chk("D_n_done", n_done, 1);
`ifdef FILTER2D_ABS_EN
    for (int i = 0; i < NPIX; i++) chk($sformatf("D_pix%0d", i), got[i], 255);
`else
    for (int i = 0; i < NPIX; i++) chk($sformatf("D_pix%0d", i), got[i], 0);
`endif

    // Same kernel, zero padding: corner would turn positive had the busy write landed.
    run_frame(1'b0, -1, -1, -1);
    chk("E_n_out", n_out, 16);
`ifdef FILTER2D_ABS_EN
    chk("E_corner", got[0], 127);
    chk("E_edge", got[1], 191);
`else
    chk("E_corner", got[0], 0);
    chk("E_edge", got[1], 0);
`endif

    // Reset at pixel 7, then a full frame with the restored default kernel.
    for (int i = 0; i < NPIX; i++) img[i] = 8'(16 * (i / W) + (i % W));
    run_frame(1'b1, -1, 7, -1);
    chk("abort_n_done", n_done, 0);
    hk = '{8, 16, 8, 16, 32, 16, 8, 16, 8};
    run_frame(1'b1, -1, -1, -1);
    chk("F_n_out", n_out, 16);
    chk("F_n_done", n_done, 1);
    chk("F_pix0_hand", got[0], 4);
    for (int i = 0; i < NPIX; i++) chk($sformatf("F_pix%0d", i), got[i], ref_pix(i % W, i / W, 1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
